// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master RAM port arbiter, M0 priority with M1 starvation guard
module ram_arbiter #(
    parameter logic [3:0] STARVE_LIMIT = 4'd3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_load,
    input  logic [2:0]  m0_load_ops,
    input  logic        m0_store,
    input  logic [2:0]  m0_store_ops,
    input  logic        m0_exception,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_load,
    input  logic [2:0]  m1_load_ops,
    input  logic        m1_store,
    input  logic [2:0]  m1_store_ops,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_w_data,
    output logic        ram_load,
    output logic [2:0]  ram_load_ops,
    output logic        ram_store,
    output logic [2:0]  ram_store_ops,
    output logic        ram_exception,
    input  logic [31:0] ram_r_data
);

    typedef enum logic [1:0] {IDLE, SVC0, SVC1} state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] starve_cnt;
    logic [3:0] starve_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // Every grant is followed by one IDLE cycle, so a slot is always two cycles long.
    always_comb begin
        state_next  = IDLE;
        starve_next = starve_cnt;
        case (state)
            IDLE: begin
                if (m1_req && (!m0_req || starve_cnt == STARVE_LIMIT))
                    state_next = SVC1;
                else if (m0_req)
                    state_next = SVC0;
                else
                    state_next = IDLE;
            end
            SVC0: begin
                state_next = IDLE;
                if (!m1_req)
                    starve_next = 4'd0;
                else if (starve_cnt >= STARVE_LIMIT)
                    starve_next = STARVE_LIMIT;
                else
                    starve_next = starve_cnt + 4'd1;
            end
            SVC1: begin
                state_next  = IDLE;
                starve_next = 4'd0;
            end
            default: begin
                state_next  = IDLE;
                starve_next = 4'd0;
            end
        endcase
    end

    // Outputs are gated by RST so an access in flight during reset never commits or acks.
    always_comb begin
        ram_addr      = 32'd0;
        ram_w_data    = 32'd0;
        ram_load      = 1'b0;
        ram_load_ops  = 3'd0;
        ram_store     = 1'b0;
        ram_store_ops = 3'd0;
        ram_exception = 1'b0;
        m0_ack        = 1'b0;
        m1_ack        = 1'b0;
        if (!RST) begin
            case (state)
                SVC0: begin
                    ram_addr      = m0_addr;
                    ram_w_data    = m0_wdata;
                    ram_load      = m0_load & m0_req;
                    ram_load_ops  = m0_load_ops;
                    ram_store     = m0_store & m0_req;
                    ram_store_ops = m0_store_ops;
                    ram_exception = m0_exception;
                    m0_ack        = m0_req;
                end
                SVC1: begin
                    ram_addr      = m1_addr;
                    ram_w_data    = m1_wdata;
                    ram_load      = m1_load & m1_req;
                    ram_load_ops  = m1_load_ops;
                    ram_store     = m1_store & m1_req;
                    ram_store_ops = m1_store_ops;
                    m1_ack        = m1_req;
                end
                default: begin
                end
            endcase
        end
    end

    assign m0_rdata = m0_ack ? ram_r_data : 32'd0;
    assign m1_rdata = m1_ack ? ram_r_data : 32'd0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed bench for ram_arbiter with slot-level arbitration model and byte RAM
module tb_ram_arbiter;

    localparam int LIM = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        m0_req, m0_load, m0_store, m0_exception;
    logic [31:0] m0_addr, m0_wdata;
    logic [2:0]  m0_load_ops, m0_store_ops;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_load, m1_store;
    logic [31:0] m1_addr, m1_wdata;
    logic [2:0]  m1_load_ops, m1_store_ops;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic [31:0] ram_addr, ram_w_data, ram_r_data;
    logic        ram_load, ram_store, ram_exception;
    logic [2:0]  ram_load_ops, ram_store_ops;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m0_acks = 0;
    int m1_acks = 0;

    always #5 CLK = ~CLK;

    ram_arbiter #(.STARVE_LIMIT(4'd3)) dut (
        .CLK(CLK), .RST(RST),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_load(m0_load), .m0_load_ops(m0_load_ops),
        .m0_store(m0_store), .m0_store_ops(m0_store_ops),
        .m0_exception(m0_exception), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_load(m1_load), .m1_load_ops(m1_load_ops),
        .m1_store(m1_store), .m1_store_ops(m1_store_ops),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_w_data(ram_w_data),
        .ram_load(ram_load), .ram_load_ops(ram_load_ops),
        .ram_store(ram_store), .ram_store_ops(ram_store_ops),
        .ram_exception(ram_exception), .ram_r_data(ram_r_data)
    );

    // Byte-wide RAM with combinational read; UART regs live at 1022 (te bit 0) and 1023 (txd).
    logic [7:0] mem [0:1023];
    logic [7:0] snap [0:1023];
    bit         mem_ready = 1'b0;

    function automatic logic [31:0] ram_read(input logic [31:0] a, input logic [2:0] ops);
        logic [9:0] b;
        logic [7:0] b0, b1, b2, b3;
        b  = a[9:0];
        b0 = mem[b];
        b1 = mem[b + 10'd1];
        b2 = mem[b + 10'd2];
        b3 = mem[b + 10'd3];
        case (ops)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b010:  return {b3, b2, b1, b0};
            3'b100:  return {24'd0, b0};
            3'b101:  return {16'd0, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    always_comb ram_r_data = ram_read(ram_addr, ram_load_ops);

    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            mem[16] <= 8'h11; mem[17] <= 8'h22; mem[18] <= 8'h33; mem[19] <= 8'h44;
            mem[32] <= 8'hCA; mem[33] <= 8'hFE; mem[34] <= 8'hBA; mem[35] <= 8'hBE;
            mem[48] <= 8'h77;
            mem_ready <= 1'b1;
        end else if (ram_store && !ram_exception) begin
            mem[ram_addr[9:0]] <= ram_w_data[7:0];
            if (ram_store_ops == 3'b001 || ram_store_ops == 3'b010)
                mem[ram_addr[9:0] + 10'd1] <= ram_w_data[15:8];
            if (ram_store_ops == 3'b010) begin
                mem[ram_addr[9:0] + 10'd2] <= ram_w_data[23:16];
                mem[ram_addr[9:0] + 10'd3] <= ram_w_data[31:24];
            end
        end
    end

    // Arbitration model: who owns the current cycle (0 none, 1 = M0, 2 = M1) and M0 wins in a row.
    int owner = 0;
    int wins = 0;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RST) begin
            owner <= 0;
            wins  <= 0;
        end else if (owner != 0) begin
            owner <= 0;
            if (owner == 1 && m1_req) wins <= (wins + 1 > LIM) ? LIM : wins + 1;
            else                      wins <= 0;
        end else if (m1_req && (!m0_req || wins == LIM)) begin
            owner <= 2;
        end else if (m0_req) begin
            owner <= 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    bit log_on = 1'b0;
    int grant_q[$];
    int grant_cyc[$];

    always @(negedge CLK) begin
        logic [31:0] ea, ew, er0, er1;
        logic [2:0]  elo, eso;
        logic        el, es, ee, ek0, ek1;
        ea = 0; ew = 0; elo = 0; eso = 0; el = 0; es = 0; ee = 0; ek0 = 0; ek1 = 0;
        if (!RST && owner == 1) begin
            ea = m0_addr; ew = m0_wdata; elo = m0_load_ops; eso = m0_store_ops;
            el = m0_load & m0_req; es = m0_store & m0_req; ee = m0_exception; ek0 = m0_req;
        end else if (!RST && owner == 2) begin
            ea = m1_addr; ew = m1_wdata; elo = m1_load_ops; eso = m1_store_ops;
            el = m1_load & m1_req; es = m1_store & m1_req; ek1 = m1_req;
        end
        er0 = ek0 ? ram_read(ea, elo) : 32'd0;
        er1 = ek1 ? ram_read(ea, elo) : 32'd0;
        chk("ram_addr", ram_addr, ea);
        chk("ram_w_data", ram_w_data, ew);
        chk("ram_load", 32'(ram_load), 32'(el));
        chk("ram_load_ops", 32'(ram_load_ops), 32'(elo));
        chk("ram_store", 32'(ram_store), 32'(es));
        chk("ram_store_ops", 32'(ram_store_ops), 32'(eso));
        chk("ram_exception", 32'(ram_exception), 32'(ee));
        chk("m0_ack", 32'(m0_ack), 32'(ek0));
        chk("m1_ack", 32'(m1_ack), 32'(ek1));
        chk("m0_rdata", m0_rdata, er0);
        chk("m1_rdata", m1_rdata, er1);
        if (m0_ack === 1'b1) m0_acks <= m0_acks + 1;
        if (m1_ack === 1'b1) m1_acks <= m1_acks + 1;
        if (log_on && m0_ack === 1'b1) begin grant_q.push_back(0); grant_cyc.push_back(cyc); end
        if (log_on && m1_ack === 1'b1) begin grant_q.push_back(1); grant_cyc.push_back(cyc); end
    end

    task automatic clear_inputs();
        m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_load = 0; m0_load_ops = 0;
        m0_store = 0; m0_store_ops = 0; m0_exception = 0;
        m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_load = 0; m1_load_ops = 0;
        m1_store = 0; m1_store_ops = 0;
    endtask

    task automatic access(input int m, input logic [31:0] a, input logic [31:0] wd,
                          input logic ld, input logic [2:0] lo, input logic st,
                          input logic [2:0] so, input logic ex,
                          output logic [31:0] rdata, output int lat, output logic exc_seen);
        bit got;
        @(posedge CLK); #1;
        if (m == 0) begin
            m0_addr = a; m0_wdata = wd; m0_load = ld; m0_load_ops = lo;
            m0_store = st; m0_store_ops = so; m0_exception = ex; m0_req = 1;
        end else begin
            m1_addr = a; m1_wdata = wd; m1_load = ld; m1_load_ops = lo;
            m1_store = st; m1_store_ops = so; m1_req = 1;
        end
        got = 0; lat = 0; rdata = 0; exc_seen = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            lat++;
            if ((m == 0 && m0_ack === 1'b1) || (m == 1 && m1_ack === 1'b1)) begin
                got = 1;
                rdata = (m == 0) ? m0_rdata : m1_rdata;
                exc_seen = ram_exception;
            end
        end
        chk("ack_within_budget", 32'(got), 32'd1);
        @(posedge CLK); #1;
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          lat, diffs, acks_before;
        logic        exs;
        int          exp_order[8];
        exp_order = '{0, 0, 0, 1, 0, 0, 0, 1};

        // 1: reset with random inputs
        RST = 1;
        clear_inputs();
        @(posedge CLK);
        @(negedge CLK);
        snap = mem;
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK); #1;
            m0_req = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
            m0_load = 1'($urandom); m0_load_ops = 3'($urandom);
            m0_store = 1'b1; m0_store_ops = 3'($urandom); m0_exception = 1'($urandom);
            m1_req = 1'b1; m1_addr = $urandom; m1_wdata = $urandom;
            m1_load = 1'($urandom); m1_load_ops = 3'($urandom);
            m1_store = 1'b1; m1_store_ops = 3'($urandom);
            @(negedge CLK);
            chk("reset_outputs", {ram_addr[29:0], ram_store, ram_load}, 32'd0);
            chk("reset_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
        end
        @(posedge CLK); #1;
        RST = 0;
        clear_inputs();
        @(negedge CLK);
        diffs = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== snap[i]) diffs++;
        chk("reset_ram_unchanged", 32'(diffs), 32'd0);
        chk("idle_after_reset", {30'd0, m0_ack, m1_ack}, 32'd0);

        // 2: M0 LW 0x10
        access(0, 32'h10, 32'h0, 1, 3'b010, 0, 3'b000, 0, rd, lat, exs);
        chk("t2_rdata", rd, 32'h44332211);
        chk("t2_latency", 32'(lat), 32'd2);

        // 3: M1 UART writes
        acks_before = m0_acks;
        access(1, 32'd1023, 32'h000000A5, 0, 3'b000, 1, 3'b000, 0, rd, lat, exs);
        access(1, 32'd1022, 32'h00000001, 0, 3'b000, 1, 3'b000, 0, rd, lat, exs);
        @(negedge CLK);
        chk("t3_uart_txd", 32'(mem[1023]), 32'hA5);
        chk("t3_uart_te", 32'(mem[1022][0]), 32'd1);
        chk("t3_no_m0_ack", 32'(m0_acks - acks_before), 32'd0);

        // 5: M0 SW under exception
        access(0, 32'h20, 32'hDEADBEEF, 0, 3'b000, 1, 3'b010, 1, rd, lat, exs);
        @(negedge CLK);
        chk("t5_ram_exception", 32'(exs), 32'd1);
        chk("t5_bytes_kept", {mem[35], mem[34], mem[33], mem[32]}, 32'hBEBAFECA);

        // 4: starvation guard with both masters requesting continuously
        @(posedge CLK); #1; RST = 1;
        @(posedge CLK); #1; RST = 0;
        log_on = 1;
        m0_addr = 32'h10; m0_load = 1; m0_load_ops = 3'b010; m0_req = 1;
        m1_addr = 32'h10; m1_load = 1; m1_load_ops = 3'b100; m1_req = 1;
        repeat (16) @(posedge CLK);
        #1;
        clear_inputs();
        repeat (2) @(posedge CLK);
        log_on = 0;
        chk("t4_grant_count", 32'(grant_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_q.size(); i++) begin
            chk($sformatf("t4_grant_%0d", i), 32'(grant_q[i]), 32'(exp_order[i]));
            if (i > 0) chk($sformatf("t4_spacing_%0d", i), 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd2);
        end

        // 6: reset during an M1 store slot
        acks_before = m1_acks;
        @(posedge CLK); #1;
        m1_addr = 32'h30; m1_wdata = 32'h5A; m1_store = 1; m1_store_ops = 3'b000; m1_req = 1;
        @(posedge CLK); #1;
        RST = 1;
        @(negedge CLK);
        chk("t6_ack_in_reset", 32'(m1_ack), 32'd0);
        chk("t6_store_in_reset", 32'(ram_store), 32'd0);
        @(posedge CLK); #1;
        RST = 0;
        clear_inputs();
        @(negedge CLK);
        chk("t6_idle_after", {30'd0, m0_ack, m1_ack}, 32'd0);
        chk("t6_byte_kept", 32'(mem[48]), 32'h77);
        chk("t6_no_m1_ack", 32'(m1_acks - acks_before), 32'd0);

        repeat (2) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
